// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio gain stage.
//   DATA_WIDTH   default signed sample width
//   gain_unity() gain code that represents a gain of exactly 1.0
//   sample_t     signed sample of DATA_WIDTH bits
//   sat()        clamp a wide signed value into sample_t range
package audio_pkg;

  localparam int unsigned DATA_WIDTH = 24;
  localparam int unsigned WideWidth  = 64;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

  function automatic int unsigned gain_unity(input int unsigned gain_frac);
    return 32'd1 << gain_frac;
  endfunction

  // In range when every bit above the sample sign bit equals the sign bit.
  function automatic sample_t sat(input logic signed [WideWidth-1:0] x);
    if ((&x[WideWidth-1:DATA_WIDTH-1]) || ~(|x[WideWidth-1:DATA_WIDTH-1])) begin
      return x[DATA_WIDTH-1:0];
    end else if (x[WideWidth-1]) begin
      return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Debouncer for one asynchronous push button.
//   i_clock  system clock
//   i_reset  synchronous active-high reset
//   i_button raw asynchronous button level
//   o_level  filtered level, changes after DEBOUNCE_CYCLES consecutive differing samples
//   o_press  one-cycle pulse on each rising edge of o_level
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_button,
  output logic o_level,
  output logic o_press
);

  localparam int unsigned CntWidth = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(DEBOUNCE_CYCLES - 1);

  logic                sync1_q, sync2_q;
  logic                level_q, level_d;
  logic                press_q, press_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    // Count samples that disagree with the filtered level; any agreeing sample restarts.
    if (sync2_q != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_button;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_level = level_q;
  assign o_press = press_q;

endmodule

// File: rtl/audio_gain_stage.sv
// Multi-channel linear gain stage with button control, 3-cycle fixed latency.
// Optional macro AUDIO_PEAK_METER_EN adds the o_peak windowed peak-hold meter.
//   i_clock, i_reset        clock, synchronous active-high reset
//   i_data, i_data_valid    packed input samples (channel n at [n*DATA_WIDTH +: DATA_WIDTH])
//   i_btnu, i_btnd          gain up/down for selected channel (asynchronous)
//   i_btnl, i_btnr          selected channel down/up, wrapping (asynchronous)
//   o_data, o_data_valid    gained, saturated samples and their strobe
//   o_sel_channel           currently selected channel
//   o_peak                  per-channel |peak| (macro only)
module audio_gain_stage
  import audio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = audio_pkg::DATA_WIDTH,
  parameter int unsigned NUM_CHANNELS    = 2,
  parameter int unsigned GAIN_WIDTH      = 5,
  parameter int unsigned GAIN_FRAC       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
`ifdef AUDIO_PEAK_METER_EN
  ,
  parameter int unsigned PEAK_WINDOW     = 48_000
`endif
) (
  input  logic                               i_clock,
  input  logic                               i_reset,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] i_data,
  input  logic                               i_data_valid,
  input  logic                               i_btnu,
  input  logic                               i_btnd,
  input  logic                               i_btnl,
  input  logic                               i_btnr,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] o_data,
  output logic                               o_data_valid,
  output logic [$clog2(NUM_CHANNELS):0]      o_sel_channel
`ifdef AUDIO_PEAK_METER_EN
  ,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] o_peak
`endif
);

  localparam int unsigned SelWidth  = $clog2(NUM_CHANNELS) + 1;
  localparam int unsigned ProdWidth = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam logic [GAIN_WIDTH-1:0] GainUnity = GAIN_WIDTH'(gain_unity(GAIN_FRAC));

  // Button front end
  logic       press_up, press_dn, press_left, press_right;
  logic [3:0] unused_level;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .i_clock(i_clock), .i_reset(i_reset), .i_button(i_btnu),
    .o_level(unused_level[0]), .o_press(press_up)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
    .i_clock(i_clock), .i_reset(i_reset), .i_button(i_btnd),
    .o_level(unused_level[1]), .o_press(press_dn)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .i_clock(i_clock), .i_reset(i_reset), .i_button(i_btnl),
    .o_level(unused_level[2]), .o_press(press_left)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .i_clock(i_clock), .i_reset(i_reset), .i_button(i_btnr),
    .o_level(unused_level[3]), .o_press(press_right)
  );

  // Gain and channel-select control
  logic [SelWidth-1:0]                sel_q, sel_d;
  logic [NUM_CHANNELS*GAIN_WIDTH-1:0] gain_q, gain_d;
  logic                               step_up, step_dn, go_left, go_right;

  // Opposing presses on the same cycle cancel.
  assign step_up  = press_up & ~press_dn;
  assign step_dn  = press_dn & ~press_up;
  assign go_left  = press_left & ~press_right;
  assign go_right = press_right & ~press_left;

  always_comb begin
    gain_d = gain_q;
    sel_d  = sel_q;
    // Gain step is decoded against the current sel_q, so it hits the old channel.
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (sel_q == SelWidth'(ch)) begin
        if (step_up && gain_q[ch*GAIN_WIDTH +: GAIN_WIDTH] != '1) begin
          gain_d[ch*GAIN_WIDTH +: GAIN_WIDTH] = gain_q[ch*GAIN_WIDTH +: GAIN_WIDTH] + GAIN_WIDTH'(1);
        end else if (step_dn && gain_q[ch*GAIN_WIDTH +: GAIN_WIDTH] != '0) begin
          gain_d[ch*GAIN_WIDTH +: GAIN_WIDTH] = gain_q[ch*GAIN_WIDTH +: GAIN_WIDTH] - GAIN_WIDTH'(1);
        end
      end
    end
    if (go_right) begin
      sel_d = (sel_q == SelWidth'(NUM_CHANNELS - 1)) ? '0 : sel_q + SelWidth'(1);
    end else if (go_left) begin
      sel_d = (sel_q == '0) ? SelWidth'(NUM_CHANNELS - 1) : sel_q - SelWidth'(1);
    end
  end

  // Datapath: S1 capture, S2 multiply, S3 shift + saturate
  logic                               v1_q, v2_q, v3_q;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_s1_q;
  logic [NUM_CHANNELS*GAIN_WIDTH-1:0] gain_s1_q;
  logic signed [ProdWidth-1:0]        prod      [NUM_CHANNELS];
  logic signed [ProdWidth-1:0]        prod_s2_q [NUM_CHANNELS];
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] sat_data;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_q;

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
    logic signed [ProdWidth-1:0]  shifted;
    logic signed [DATA_WIDTH-1:0] sat_val;

    // Gain is unsigned; the extra zero bit makes it a non-negative signed operand.
    assign prod[ch] = ProdWidth'(signed'(data_s1_q[ch*DATA_WIDTH +: DATA_WIDTH])) *
                      ProdWidth'(signed'({1'b0, gain_s1_q[ch*GAIN_WIDTH +: GAIN_WIDTH]}));
    assign shifted  = prod_s2_q[ch] >>> GAIN_FRAC;

    if (DATA_WIDTH == audio_pkg::DATA_WIDTH && ProdWidth <= WideWidth) begin : g_pkg_sat
      assign sat_val = sat(WideWidth'(shifted));
    end else begin : g_local_sat
      always_comb begin
        if ((&shifted[ProdWidth-1:DATA_WIDTH-1]) || ~(|shifted[ProdWidth-1:DATA_WIDTH-1])) begin
          sat_val = shifted[DATA_WIDTH-1:0];
        end else if (shifted[ProdWidth-1]) begin
          sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
          sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
      end
    end

    assign sat_data[ch*DATA_WIDTH +: DATA_WIDTH] = sat_val;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sel_q     <= '0;
      gain_q    <= {NUM_CHANNELS{GainUnity}};
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      data_s1_q <= '0;
      gain_s1_q <= '0;
      data_q    <= '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) prod_s2_q[ch] <= '0;
    end else begin
      sel_q  <= sel_d;
      gain_q <= gain_d;
      v1_q   <= i_data_valid;
      v2_q   <= v1_q;
      v3_q   <= v2_q;
      // Gain snapshot travels with its sample so later steps leave it alone.
      if (i_data_valid) begin
        data_s1_q <= i_data;
        gain_s1_q <= gain_q;
      end
      if (v1_q) begin
        for (int ch = 0; ch < NUM_CHANNELS; ch++) prod_s2_q[ch] <= prod[ch];
      end
      if (v2_q) data_q <= sat_data;
    end
  end

  assign o_data        = data_q;
  assign o_data_valid  = v3_q;
  assign o_sel_channel = sel_q;

`ifdef AUDIO_PEAK_METER_EN
  localparam int unsigned WinWidth = $clog2(PEAK_WINDOW + 1);

  logic [WinWidth-1:0]                win_q;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] peak_q, peak_d;
  logic [DATA_WIDTH-1:0]              smp, mag;

  always_comb begin
    peak_d = peak_q;
    smp    = '0;
    mag    = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      smp = sat_data[ch*DATA_WIDTH +: DATA_WIDTH];
      // |most negative| does not fit, so it clamps to the positive maximum.
      if (smp == {1'b1, {(DATA_WIDTH-1){1'b0}}}) begin
        mag = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else if (smp[DATA_WIDTH-1]) begin
        mag = -smp;
      end else begin
        mag = smp;
      end
      if (win_q == WinWidth'(PEAK_WINDOW) || mag > peak_q[ch*DATA_WIDTH +: DATA_WIDTH]) begin
        peak_d[ch*DATA_WIDTH +: DATA_WIDTH] = mag;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      peak_q <= '0;
      win_q  <= '0;
    end else if (v2_q) begin
      peak_q <= peak_d;
      win_q  <= (win_q == WinWidth'(PEAK_WINDOW)) ? WinWidth'(1) : win_q + WinWidth'(1);
    end
  end

  assign o_peak = peak_q;
`endif

endmodule
